// File: rtl/line_buffer_ctrl_pkg.sv
// line_buffer_ctrl_pkg: FSM encodings and width helper shared by the line buffer
// controllers.
package line_buffer_ctrl_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   function automatic int clog2(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction
endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: raster column/row position with enable, wrap and a
// last-pixel flag.
module frame_pos_counter
   import line_buffer_ctrl_pkg::*;
#(
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 6,
   localparam int CW = clog2(IMG_WIDTH),
   localparam int RW = clog2(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);
   logic col_wrap;
   assign col_wrap = col == CW'(IMG_WIDTH - 1);
   assign last     = col_wrap && row == RW'(IMG_HEIGHT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         col <= col_wrap ? '0 : col + CW'(1);
         row <= last ? '0 : col_wrap ? row + RW'(1) : row;
      end
endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences the row buffer cascade and KxK window register for a
// raster pixel stream and hands complete windows to the convolution engine.
module line_buffer_ctrl
   import line_buffer_ctrl_pkg::*;
#(
   parameter int IMG_WIDTH   = 8,
   parameter int IMG_HEIGHT  = 6,
   parameter int KERNEL_SIZE = 3,
   localparam int CW = clog2(IMG_WIDTH),
   localparam int RW = clog2(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          rb_enable,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          busy,
   output logic          frame_done
);
   logic [1:0]    state, state_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last, accept, gen;
   frame_pos_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_pos (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .col  (col),
      .row  (row),
      .last (last)
   );
   // A single output register: a new pixel may enter whenever the held window leaves.
   assign in_ready   = state == RUN && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign rb_enable  = accept;
   assign gen        = accept && row >= RW'(KERNEL_SIZE - 1) && col >= CW'(KERNEL_SIZE - 1);
   assign busy       = state == RUN || state == DONE;
   assign frame_done = state == DONE && !out_valid;
   always_comb
      state_nxt = (state == IDLE && start)          ? RUN  :
                  (state == RUN && accept && last)  ? DONE :
                  frame_done                        ? IDLE : state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else begin
         state <= state_nxt;
         if (gen) begin
            out_valid <= 1'b1;
            win_row   <= row - RW'(KERNEL_SIZE - 1);
            win_col   <= col - CW'(KERNEL_SIZE - 1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed frames on the default 8x6/K=3 controller plus a
// vector table on a 4x2/K=1 instance.
module tb_line_buffer_ctrl;
   localparam int W = 8, H = 6, K = 3;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic m_start = 0, m_iv = 0, m_or = 0;
   logic m_ir, m_rb, m_ov, m_busy, m_fd;
   logic [2:0] m_wr, m_wc;
   logic s_start = 0, s_iv = 0, s_or = 0;
   logic s_ir, s_rb, s_ov, s_busy, s_fd;
   logic [0:0] s_wr;
   logic [1:0] s_wc;
   line_buffer_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) u_main (
      .clk(clk), .rst_n(rst_n), .start(m_start), .in_valid(m_iv), .in_ready(m_ir),
      .rb_enable(m_rb), .out_valid(m_ov), .out_ready(m_or), .win_row(m_wr),
      .win_col(m_wc), .busy(m_busy), .frame_done(m_fd));
   line_buffer_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .KERNEL_SIZE(1)) u_k1 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_iv), .in_ready(s_ir),
      .rb_enable(s_rb), .out_valid(s_ov), .out_ready(s_or), .win_row(s_wr),
      .win_col(s_wc), .busy(s_busy), .frame_done(s_fd));
   int nvec = 0, nerr = 0;
   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   int cyc_n = 0, acc, rbe, rb_bad, fd_n, fd_cyc, last_cons, first_acc, first_prev;
   bit mon_en = 0, seen_ov, prev_acc;
   int wq[$];
   initial forever begin
      @(negedge clk);
      #2;
      cyc_n++;
      if (mon_en) begin
         if (m_ov && !seen_ov) begin
            seen_ov    = 1;
            first_acc  = acc;
            first_prev = prev_acc;
         end
         if (m_ov && m_or) begin
            wq.push_back(m_wr * 100 + m_wc);
            last_cons = cyc_n;
         end
         if (m_fd) begin
            fd_n++;
            fd_cyc = cyc_n;
         end
         prev_acc = m_iv && m_ir;
         if (prev_acc) acc++;
         if (m_rb) rbe++;
         if (m_rb != prev_acc) rb_bad++;
      end
   end
   task automatic reset_chk(input string tag);
      chk({tag, "_in_ready"}, m_ir, 0);
      chk({tag, "_rb_enable"}, m_rb, 0);
      chk({tag, "_out_valid"}, m_ov, 0);
      chk({tag, "_win_row"}, m_wr, 0);
      chk({tag, "_win_col"}, m_wc, 0);
      chk({tag, "_busy"}, m_busy, 0);
      chk({tag, "_frame_done"}, m_fd, 0);
   endtask
   task automatic run_frame(input string tag, input bit bub, input bit bp, input bit spam,
                            input int rst_at);
      int bp_left = 0, bp_r = 0, bp_c = 0, k = 0;
      bit bp_done = 0;
      acc = 0; rbe = 0; rb_bad = 0; fd_n = 0; fd_cyc = 0; last_cons = 0;
      first_acc = 0; first_prev = 0; seen_ov = 0; prev_acc = 0;
      wq.delete();
      mon_en = 1;
      @(negedge clk);
      m_start = 1; m_iv = 0; m_or = 1;
      @(negedge clk);
      m_start = 0;
      for (int n = 0; n < 600 && fd_n == 0; n++) begin
         @(negedge clk);
         if (rst_at > 0 && acc >= rst_at) begin
            rst_n = 0; m_iv = 0; m_start = 0;
            #1;
            reset_chk({tag, "_rst"});
            @(negedge clk);
            rst_n = 1;
            mon_en = 0;
            return;
         end
         m_iv    = bub ? n[0] : 1'b1;
         m_start = spam && m_busy;
         if (bp && !bp_done && m_ov && wq.size() == 3) begin
            bp_left = 5; bp_done = 1; bp_r = m_wr; bp_c = m_wc;
         end
         m_or = bp_left == 0;
         if (bp_left > 0) begin
            bp_left--;
            #1;
            chk({tag, "_bp_in_ready"}, m_ir, 0);
            chk({tag, "_bp_rb_enable"}, m_rb, 0);
            chk({tag, "_bp_out_valid"}, m_ov, 1);
            chk({tag, "_bp_win_row"}, m_wr, bp_r);
            chk({tag, "_bp_win_col"}, m_wc, bp_c);
         end
      end
      @(negedge clk);
      m_iv = 0; m_start = 0;
      #1;
      chk({tag, "_busy_after"}, m_busy, 0);
      repeat (3) @(negedge clk);
      mon_en = 0;
      chk({tag, "_frame_done_count"}, fd_n, 1);
      chk({tag, "_accepts"}, acc, W * H);
      chk({tag, "_rb_pulses"}, rbe, W * H);
      chk({tag, "_rb_not_accept"}, rb_bad, 0);
      chk({tag, "_first_win_acc"}, first_acc, (K - 1) * W + K);
      chk({tag, "_first_win_lat"}, first_prev, 1);
      chk({tag, "_fd_after_consume"}, fd_cyc - last_cons, 1);
      chk({tag, "_windows"}, wq.size(), (W - K + 1) * (H - K + 1));
      for (int r = 0; r <= H - K; r++)
         for (int c = 0; c <= W - K; c++) begin
            if (k < wq.size()) chk($sformatf("%s_win%0d", tag, k), wq[k], r * 100 + c);
            k++;
         end
   endtask
   typedef struct {
      logic st, iv, ordy, ir, rb, ov;
      int   r, c;
      logic busy, fd;
   } vec_t;
   vec_t tv[18];
   initial begin
      tv[0]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      tv[1]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      tv[2]  = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0};
      tv[3]  = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
      tv[4]  = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 0};
      tv[5]  = '{0, 1, 1, 1, 1, 1, 0, 2, 1, 0};
      tv[6]  = '{0, 1, 0, 0, 0, 1, 0, 3, 1, 0};
      tv[7]  = '{0, 1, 0, 0, 0, 1, 0, 3, 1, 0};
      tv[8]  = '{0, 0, 1, 1, 0, 1, 0, 3, 1, 0};
      tv[9]  = '{0, 1, 0, 1, 1, 0, 0, 3, 1, 0};
      tv[10] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 0};
      tv[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      tv[12] = '{1, 1, 1, 1, 1, 1, 1, 2, 1, 0};
      tv[13] = '{1, 1, 0, 0, 0, 1, 1, 3, 1, 0};
      tv[14] = '{0, 1, 1, 0, 0, 1, 1, 3, 1, 0};
      tv[15] = '{1, 1, 1, 0, 0, 0, 1, 3, 1, 1};
      tv[16] = '{0, 1, 1, 0, 0, 0, 1, 3, 0, 0};
      tv[17] = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 0};
      #3;
      reset_chk("por");
      @(negedge clk);
      rst_n = 1;
      run_frame("full", 0, 0, 0, 0);
      run_frame("bubble_bp_start", 1, 1, 1, 0);
      run_frame("midframe", 0, 0, 0, 30);
      run_frame("after_rst", 0, 0, 0, 0);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         s_start = tv[i].st; s_iv = tv[i].iv; s_or = tv[i].ordy;
         #1;
         chk($sformatf("k1_v%0d_in_ready", i), s_ir, tv[i].ir);
         chk($sformatf("k1_v%0d_rb_enable", i), s_rb, tv[i].rb);
         chk($sformatf("k1_v%0d_out_valid", i), s_ov, tv[i].ov);
         chk($sformatf("k1_v%0d_win_row", i), s_wr, tv[i].r);
         chk($sformatf("k1_v%0d_win_col", i), s_wc, tv[i].c);
         chk($sformatf("k1_v%0d_busy", i), s_busy, tv[i].busy);
         chk($sformatf("k1_v%0d_frame_done", i), s_fd, tv[i].fd);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
